fifo_beat_packer: RTL

//  Downstream pop-side consumer of a first-word-fall-through RAM FIFO (valid/pop interface).

---
 rtl/fifo_beat_packer.sv | 84 ++++++++
 1 files changed

// File: rtl/fifo_beat_packer.sv
// Packs RATIO narrow words from a first-word-fall-through FIFO into one wide beat.
// The beat carries a per-lane keep mask and a last flag, and leaves on a valid/ready stream.
module fifo_beat_packer #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned OUT_WIDTH = IN_WIDTH * RATIO,
  parameter int unsigned CNT_WIDTH = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_valid,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  input  logic                 fifo_last,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [RATIO-1:0]     out_keep,
  output logic                 out_last,
  output logic [31:0]          pkt_cnt,
  output logic                 idle
);

  logic [CNT_WIDTH-1:0] lane_idx;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic [RATIO-1:0]     acc_keep;
  logic [RATIO-1:0]     lane_bit;
  logic                 completing;
  logic                 out_free;
  logic                 load;

  assign completing = (lane_idx == CNT_WIDTH'(RATIO - 1)) | fifo_last;
  assign out_free   = ~out_valid | out_ready;
  // A completing word may only leave the FIFO when the output register can take the beat.
  assign fifo_pop   = fifo_valid & ~rst & (~completing | out_free);
  assign load       = fifo_pop & completing;
  assign idle       = (lane_idx == '0) & ~out_valid;
  assign lane_bit   = RATIO'(1) << lane_idx;

  // Lanes at and above lane_idx are always zero in acc, so an overlay is enough.
  always_comb begin
    merged = acc;
    merged[lane_idx*IN_WIDTH +: IN_WIDTH] = fifo_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_idx  <= '0;
      acc       <= '0;
      acc_keep  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (fifo_pop && !completing) begin
        acc      <= merged;
        acc_keep <= acc_keep | lane_bit;
        lane_idx <= lane_idx + CNT_WIDTH'(1);
      end
      if (load) begin
        out_data  <= merged;
        out_keep  <= acc_keep | lane_bit;
        out_last  <= fifo_last;
        out_valid <= 1'b1;
        acc       <= '0;
        acc_keep  <= '0;
        lane_idx  <= '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (out_valid && out_ready && out_last) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule
